vend_credit_fsm: RTL and testbench
==================================

Name: vend_credit_fsm

Overview:
- Parametrised coin-operated vending controller. It is the next generation of the fixed 50c/1 EUR, 150c-price vending state machine.
- Accumulates credit from three coin denominations against a configurable price and pulses a vend output.
- Returns change or a cancelled credit as a train of single-denomination change pulses, and rejects coins while busy.
- Sits behind the TinyTapeout wrapper: coin code from ui_in, status on uo_out.

Parameters:
- CREDIT_W, 6, credit register width in money units; max credit 2^CREDIT_W-1.
- PRICE, 15, product price in units (1 unit = 10c).
- COIN_A, 5, value of coin code 01.
- COIN_B, 10, value of coin code 10.
- COIN_C, 20, value of coin code 11.
- CHANGE_UNIT, 5, value returned per change pulse. PRICE and all coin values must be multiples of it; this is checked by an elaboration-time assertion.
- VEND_CYCLES, 2, vend_o high time in cycles (>=1).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, synchronous active-high reset. The name is kept for the wrapper; 1 = reset.
- coin_i, input, 2, coin event per cycle: 00 none, 01 A, 10 B, 11 C. Each non-zero cycle is one coin.
- cancel_i, input, 1, request refund of the current credit.
- credit_o, output, CREDIT_W, current credit (registered).
- vend_o, output, 1, product release.
- change_o, output, 1, one pulse = one CHANGE_UNIT returned.
- coin_reject_o, output, 1, coin from the previous cycle was rejected (1-cycle pulse).
- busy_o, output, 1, high in any state other than COLLECT.

Behaviour:
- All outputs are registered. Reset (rst_n=1 at an edge) forces:
  - state COLLECT, credit 0, vend counter 0;
  - vend_o, change_o, coin_reject_o, busy_o all 0.
  - Reset wins over every other input, in any state, including mid-vend and mid-change.
- State COLLECT:
  - Coin at edge n with credit+val <= 2^CREDIT_W-1 and credit+val < PRICE: credit_o = credit+val from cycle n+1.
  - Coin with credit+val >= PRICE: in one edge, credit <= credit+val-PRICE, state <= VEND, vend_o=1 from n+1.
  - Coin that would overflow credit: credit unchanged, coin_reject_o=1 in n+1.
  - cancel_i=1 with credit>0: state <= CHANGE_HI; no vend.
  - cancel_i=1 with credit=0: ignored.
  - cancel_i and a coin in the same cycle: cancel wins, coin rejected (coin_reject_o pulse), refund covers the prior credit only.
- State VEND:
  - vend_o stays high for exactly VEND_CYCLES cycles.
  - Then state <= CHANGE_HI if credit>0, else COLLECT.
- State CHANGE_HI:
  - change_o=1 for one cycle; credit <= credit-CHANGE_UNIT.
  - Next state is CHANGE_LO.
- State CHANGE_LO:
  - change_o=0 for one cycle.
  - Then CHANGE_HI if credit>0, else COLLECT.
  - Pulse train is HI/LO alternating; N pulses occupy 2N cycles.
- Busy states (VEND, CHANGE_HI, CHANGE_LO):
  - Every non-zero coin_i is rejected: credit unchanged, coin_reject_o pulse in the next cycle.
  - cancel_i is ignored.
- busy_o = (state != COLLECT) and is registered with the state.
- Credit arithmetic uses CREDIT_W+1 bits internally to detect overflow. credit_o never wraps.
- vend_o and change_o are never high in the same cycle.

Test Plan:
- Default params; coin A at cycles 0, 2, 4:
  - credit_o reads 5, 10, then 0;
  - vend_o high for cycles 5-6; change_o never pulses; busy_o low again from cycle 7.
- Coin A at cycle 0, coin C at cycle 2:
  - credit 5, then 25-15=10 with vend_o for 2 cycles;
  - then change_o pattern 1,0,1,0 as credit_o goes 5, 0;
  - back to COLLECT with credit_o=0.
- Coin B, then cancel_i 3 cycles later:
  - no vend_o;
  - change_o pulses exactly twice with a 1-cycle gap; credit_o ends at 0.
- Coin B with cancel_i in the same cycle at credit 5: one change pulse and coin_reject_o=1 next cycle. Separately, coin A during VEND: coin_reject_o pulse, credit and vend timing unchanged.
- Overflow with CREDIT_W=4 and PRICE=15: coin C at credit 0 → rejected, credit stays 0. Coin B, then A → vend, credit 0.
- Reset (rst_n=1 for one cycle) during the second CHANGE_HI of a 2-pulse refund:
  - next cycle credit_o=0, change_o=0, busy_o=0;
  - no further pulses; a new coin A is then accepted normally.

Source files
------------

// File: rtl/vend_credit_fsm.sv
// Coin-operated vending controller: accumulates credit against PRICE, pulses vend_o,
// and pays change or refunds as a train of CHANGE_UNIT pulses on change_o.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_COLLECT   | idle, accepting coins and cancel
// S_VEND      | vend_o high for VEND_CYCLES cycles, coins rejected
// S_CHANGE_HI | change_o high, one CHANGE_UNIT paid out on leaving
// S_CHANGE_LO | gap cycle between change pulses
module vend_credit_fsm #(
   parameter int unsigned CREDIT_W    = 6,
   parameter int unsigned PRICE       = 15,
   parameter int unsigned COIN_A      = 5,
   parameter int unsigned COIN_B      = 10,
   parameter int unsigned COIN_C      = 20,
   parameter int unsigned CHANGE_UNIT = 5,
   parameter int unsigned VEND_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          coin_i,
   input  logic                cancel_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                vend_o,
   output logic                change_o,
   output logic                coin_reject_o,
   output logic                busy_o
);

   localparam int unsigned SW    = CREDIT_W + 1;
   localparam int unsigned CNT_W = $clog2(VEND_CYCLES + 1);

   localparam logic [SW-1:0]       VAL_A      = SW'(COIN_A);
   localparam logic [SW-1:0]       VAL_B      = SW'(COIN_B);
   localparam logic [SW-1:0]       VAL_C      = SW'(COIN_C);
   localparam logic [SW-1:0]       PRICE_W    = SW'(PRICE);
   localparam logic [SW-1:0]       MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [CREDIT_W-1:0] UNIT_W     = CREDIT_W'(CHANGE_UNIT);
   localparam logic [CNT_W-1:0]    VEND_LOAD  = CNT_W'(VEND_CYCLES - 1);

   // Change is paid in whole units, so every amount that can become credit must be a multiple.
   if (CHANGE_UNIT == 0 || (PRICE % CHANGE_UNIT) != 0 || (COIN_A % CHANGE_UNIT) != 0 ||
       (COIN_B % CHANGE_UNIT) != 0 || (COIN_C % CHANGE_UNIT) != 0) begin : g_bad_unit
      $error("vend_credit_fsm: PRICE and coin values must be multiples of CHANGE_UNIT");
   end
   if (VEND_CYCLES < 1) begin : g_bad_vend
      $error("vend_credit_fsm: VEND_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_COLLECT   = 2'd0,
      S_VEND      = 2'd1,
      S_CHANGE_HI = 2'd2,
      S_CHANGE_LO = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit, credit_nxt;
   logic [CNT_W-1:0]    vend_cnt, vend_cnt_nxt;
   logic                reject_nxt;
   logic [SW-1:0]       coin_val;
   logic [SW-1:0]       sum;
   logic [SW-1:0]       remain;
   logic                coin_seen;

   always_comb begin
      coin_val = '0;
      case (coin_i)
         2'b01:   coin_val = VAL_A;
         2'b10:   coin_val = VAL_B;
         2'b11:   coin_val = VAL_C;
         default: coin_val = '0;
      endcase
   end

   assign coin_seen = (coin_i != 2'b00);
   assign sum       = {1'b0, credit} + coin_val;
   assign remain    = sum - PRICE_W;

   always_comb begin
      state_nxt    = state;
      credit_nxt   = credit;
      vend_cnt_nxt = vend_cnt;
      reject_nxt   = 1'b0;
      case (state)
         S_COLLECT: begin
            if (cancel_i && (credit != '0)) begin
               // Refund covers only the credit held before this cycle.
               state_nxt  = S_CHANGE_HI;
               reject_nxt = coin_seen;
            end else if (coin_seen) begin
               if (sum > MAX_CREDIT) begin
                  reject_nxt = 1'b1;
               end else if (sum >= PRICE_W) begin
                  credit_nxt   = remain[CREDIT_W-1:0];
                  vend_cnt_nxt = VEND_LOAD;
                  state_nxt    = S_VEND;
               end else begin
                  credit_nxt = sum[CREDIT_W-1:0];
               end
            end
         end
         S_VEND: begin
            reject_nxt = coin_seen;
            if (vend_cnt == '0) begin
               state_nxt = (credit != '0) ? S_CHANGE_HI : S_COLLECT;
            end else begin
               vend_cnt_nxt = vend_cnt - 1'b1;
            end
         end
         S_CHANGE_HI: begin
            reject_nxt = coin_seen;
            credit_nxt = credit - UNIT_W;
            state_nxt  = S_CHANGE_LO;
         end
         S_CHANGE_LO: begin
            reject_nxt = coin_seen;
            state_nxt  = (credit != '0) ? S_CHANGE_HI : S_COLLECT;
         end
         default: begin
            state_nxt = S_COLLECT;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state         <= S_COLLECT;
         credit        <= '0;
         vend_cnt      <= '0;
         vend_o        <= 1'b0;
         change_o      <= 1'b0;
         coin_reject_o <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         state         <= state_nxt;
         credit        <= credit_nxt;
         vend_cnt      <= vend_cnt_nxt;
         vend_o        <= (state_nxt == S_VEND);
         change_o      <= (state_nxt == S_CHANGE_HI);
         coin_reject_o <= reject_nxt;
         busy_o        <= (state_nxt != S_COLLECT);
      end
   end

   assign credit_o = credit;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Scoreboard bench: each driven cycle pushes the hand-derived expected outputs,
// a monitor pops and compares them one cycle later.
module tb_vend_credit_fsm;

   localparam logic [1:0] NC = 2'b00, CA = 2'b01, CB = 2'b10, CC = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] coin_i = 2'b00;
   logic       cancel_i = 1'b0;

   logic [5:0] credit1;
   logic       vend1, change1, rej1, busy1;
   logic [3:0] credit2;
   logic       vend2, change2, rej2, busy2;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      tag;
      bit         sel;
      logic [9:0] val;
   } exp_t;

   exp_t expq[$];

   always #5 clk = ~clk;

   vend_credit_fsm u_dut (
      .clk(clk), .rst_n(rst_n), .coin_i(coin_i), .cancel_i(cancel_i),
      .credit_o(credit1), .vend_o(vend1), .change_o(change1),
      .coin_reject_o(rej1), .busy_o(busy1)
   );

   vend_credit_fsm #(.CREDIT_W(4), .PRICE(15)) u_dut_w4 (
      .clk(clk), .rst_n(rst_n), .coin_i(coin_i), .cancel_i(cancel_i),
      .credit_o(credit2), .vend_o(vend2), .change_o(change2),
      .coin_reject_o(rej2), .busy_o(busy2)
   );

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got cr=%0d v=%b c=%b r=%b b=%b, want cr=%0d v=%b c=%b r=%b b=%b",
                  tag, obs[9:4], obs[3], obs[2], obs[1], obs[0],
                  exp[9:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // One cycle of stimulus; expected values are the outputs after the coming edge.
   task automatic step(input string tag, input bit sel, input logic [1:0] coin,
                       input logic cancel, input logic rst, input logic [5:0] cr,
                       input logic v, input logic c, input logic r, input logic b);
      exp_t e;
      @(negedge clk);
      coin_i   = coin;
      cancel_i = cancel;
      rst_n    = rst;
      e.tag = tag;
      e.sel = sel;
      e.val = {cr, v, c, r, b};
      expq.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (expq.size() > 0) begin
         exp_t e;
         logic [9:0] obs;
         e = expq.pop_front();
         obs = e.sel ? {2'b00, credit2, vend2, change2, rej2, busy2}
                     : {credit1, vend1, change1, rej1, busy1};
         chk(e.tag, obs, e.val);
         if (e.sel ? (vend2 && change2) : (vend1 && change1))
            chk({e.tag, "_excl"}, 10'd1, 10'd0);
      end
   end

   initial begin
      step("rst0", 0, NC, 0, 1, 0, 0, 0, 0, 0);
      step("rst1", 0, NC, 0, 1, 0, 0, 0, 0, 0);
      step("cancel_zero", 0, NC, 1, 0, 0, 0, 0, 0, 0);

      // three A coins -> exact price
      step("s1_e0", 0, CA, 0, 0, 5,  0, 0, 0, 0);
      step("s1_e1", 0, NC, 0, 0, 5,  0, 0, 0, 0);
      step("s1_e2", 0, CA, 0, 0, 10, 0, 0, 0, 0);
      step("s1_e3", 0, NC, 0, 0, 10, 0, 0, 0, 0);
      step("s1_e4", 0, CA, 0, 0, 0,  1, 0, 0, 1);
      step("s1_e5", 0, NC, 0, 0, 0,  1, 0, 0, 1);
      step("s1_e6", 0, NC, 0, 0, 0,  0, 0, 0, 0);
      step("s1_e7", 0, NC, 0, 0, 0,  0, 0, 0, 0);

      // A then C -> vend with 10 change
      step("s2_e0", 0, CA, 0, 0, 5,  0, 0, 0, 0);
      step("s2_e1", 0, NC, 0, 0, 5,  0, 0, 0, 0);
      step("s2_e2", 0, CC, 0, 0, 10, 1, 0, 0, 1);
      step("s2_e3", 0, NC, 0, 0, 10, 1, 0, 0, 1);
      step("s2_e4", 0, NC, 0, 0, 10, 0, 1, 0, 1);
      step("s2_e5", 0, NC, 0, 0, 5,  0, 0, 0, 1);
      step("s2_e6", 0, NC, 0, 0, 5,  0, 1, 0, 1);
      step("s2_e7", 0, NC, 0, 0, 0,  0, 0, 0, 1);
      step("s2_e8", 0, NC, 0, 0, 0,  0, 0, 0, 0);
      step("s2_e9", 0, NC, 0, 0, 0,  0, 0, 0, 0);

      // B, cancel 3 cycles later; coin and cancel during refund are ignored/rejected
      step("s3_e0", 0, CB, 0, 0, 10, 0, 0, 0, 0);
      step("s3_e1", 0, NC, 0, 0, 10, 0, 0, 0, 0);
      step("s3_e2", 0, NC, 0, 0, 10, 0, 0, 0, 0);
      step("s3_e3", 0, NC, 1, 0, 10, 0, 1, 0, 1);
      step("s3_e4", 0, CB, 0, 0, 5,  0, 0, 1, 1);
      step("s3_e5", 0, NC, 1, 0, 5,  0, 1, 0, 1);
      step("s3_e6", 0, NC, 0, 0, 0,  0, 0, 0, 1);
      step("s3_e7", 0, NC, 0, 0, 0,  0, 0, 0, 0);
      step("s3_e8", 0, NC, 0, 0, 0,  0, 0, 0, 0);

      // cancel and coin together: refund prior credit only
      step("s4a_e0", 0, CA, 0, 0, 5, 0, 0, 0, 0);
      step("s4a_e1", 0, CB, 1, 0, 5, 0, 1, 1, 1);
      step("s4a_e2", 0, NC, 0, 0, 0, 0, 0, 0, 1);
      step("s4a_e3", 0, NC, 0, 0, 0, 0, 0, 0, 0);

      // coin during VEND rejected, vend timing unchanged
      step("s4b_e0", 0, CB, 0, 0, 10, 0, 0, 0, 0);
      step("s4b_e1", 0, CA, 0, 0, 0,  1, 0, 0, 1);
      step("s4b_e2", 0, CA, 0, 0, 0,  1, 0, 1, 1);
      step("s4b_e3", 0, NC, 0, 0, 0,  0, 0, 0, 0);

      // reset during the second CHANGE_HI
      step("s6_e0", 0, CB, 0, 0, 10, 0, 0, 0, 0);
      step("s6_e1", 0, NC, 1, 0, 10, 0, 1, 0, 1);
      step("s6_e2", 0, NC, 0, 0, 5,  0, 0, 0, 1);
      step("s6_e3", 0, NC, 0, 0, 5,  0, 1, 0, 1);
      step("s6_rst", 0, NC, 0, 1, 0, 0, 0, 0, 0);
      step("s6_e5", 0, NC, 0, 0, 0,  0, 0, 0, 0);
      step("s6_e6", 0, CA, 0, 0, 5,  0, 0, 0, 0);
      step("s6_e7", 0, NC, 0, 0, 5,  0, 0, 0, 0);
      step("s6_e8", 0, NC, 1, 0, 5,  0, 1, 0, 1);
      step("s6_e9", 0, NC, 0, 0, 0,  0, 0, 0, 1);
      step("s6_e10", 0, NC, 0, 0, 0, 0, 0, 0, 0);

      // overflow on the 4-bit credit instance
      step("w4_rst", 1, NC, 0, 1, 0, 0, 0, 0, 0);
      step("w4_ovf", 1, CC, 0, 0, 0, 0, 0, 1, 0);
      step("w4_e1", 1, NC, 0, 0, 0,  0, 0, 0, 0);
      step("w4_e2", 1, CB, 0, 0, 10, 0, 0, 0, 0);
      step("w4_e3", 1, CA, 0, 0, 0,  1, 0, 0, 1);
      step("w4_e4", 1, NC, 0, 0, 0,  1, 0, 0, 1);
      step("w4_e5", 1, NC, 0, 0, 0,  0, 0, 0, 0);

      for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
      chk("drain", 10'(expq.size()), 10'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
